// File: rtl/int_issue_queue_if.sv
// Dispatch / CDB / issue bundle for the integer issue queue.
// The slave modport is the queue side; master is the dispatch/ALU side.
interface int_issue_queue_if #(
    parameter int TAG_W = 6
);
    // Dispatch write request
    logic             Dispatch_en_Int;
    logic [3:0]       Dispatch_Opcode;
    logic [4:0]       Dispatch_Shfamt;
    logic [31:0]      Dispatch_Imm_LS;
    logic             Dispatch_Type_I;
    logic             Dispatch_Branch;
    logic [31:0]      Dispatch_Rs_Data;
    logic [31:0]      Dispatch_Rt_Data;
    logic [TAG_W-1:0] Dispatch_Rs_Tag;
    logic [TAG_W-1:0] Dispatch_Rt_Tag;
    logic             Dispatch_Rs_Valid;
    logic             Dispatch_Rt_Valid;
    logic [TAG_W-1:0] Dispatch_Rd_Tag;
    // Result broadcast
    logic             Cdb_Valid;
    logic [TAG_W-1:0] Cdb_Tag;
    logic [31:0]      Cdb_Data;
    // Issue side
    logic             Issue_Ready;
    logic             IssueQue_Full;
    logic [3:0]       IssueQue_Count;
    logic             Issue_Valid;
    logic [3:0]       Issue_Opcode;
    logic [4:0]       Issue_Shfamt;
    logic [31:0]      Issue_Rs_Data;
    logic [31:0]      Issue_Rt_Data;
    logic [31:0]      Issue_Imm;
    logic [TAG_W-1:0] Issue_Rd_Tag;
    logic             Issue_Branch;

    modport slave (
        input  Dispatch_en_Int, Dispatch_Opcode, Dispatch_Shfamt, Dispatch_Imm_LS,
               Dispatch_Type_I, Dispatch_Branch, Dispatch_Rs_Data, Dispatch_Rt_Data,
               Dispatch_Rs_Tag, Dispatch_Rt_Tag, Dispatch_Rs_Valid, Dispatch_Rt_Valid,
               Dispatch_Rd_Tag, Cdb_Valid, Cdb_Tag, Cdb_Data, Issue_Ready,
        output IssueQue_Full, IssueQue_Count, Issue_Valid, Issue_Opcode, Issue_Shfamt,
               Issue_Rs_Data, Issue_Rt_Data, Issue_Imm, Issue_Rd_Tag, Issue_Branch
    );

    modport master (
        output Dispatch_en_Int, Dispatch_Opcode, Dispatch_Shfamt, Dispatch_Imm_LS,
               Dispatch_Type_I, Dispatch_Branch, Dispatch_Rs_Data, Dispatch_Rt_Data,
               Dispatch_Rs_Tag, Dispatch_Rt_Tag, Dispatch_Rs_Valid, Dispatch_Rt_Valid,
               Dispatch_Rd_Tag, Cdb_Valid, Cdb_Tag, Cdb_Data, Issue_Ready,
        input  IssueQue_Full, IssueQue_Count, Issue_Valid, Issue_Opcode, Issue_Shfamt,
               Issue_Rs_Data, Issue_Rt_Data, Issue_Imm, Issue_Rd_Tag, Issue_Branch
    );
endinterface

// File: rtl/int_issue_queue.sv
// Integer issue queue: collapsing array (entry 0 oldest), CDB operand snooping,
// oldest-ready select to the integer ALU.
// Optional feature: define INT_IQ_FLUSH_EN to add a synchronous Flush input.
module int_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input logic Clk,
    input logic Resetb,
`ifdef INT_IQ_FLUSH_EN
    input logic Flush,
`endif
    int_issue_queue_if.slave bus
);

    typedef struct packed {
        logic             valid;
        logic [3:0]       opcode;
        logic [4:0]       shfamt;
        logic [31:0]      imm;
        logic             branch;
        logic [TAG_W-1:0] rd_tag;
        logic [31:0]      rs_data;
        logic [TAG_W-1:0] rs_tag;
        logic             rs_rdy;
        logic [31:0]      rt_data;
        logic [TAG_W-1:0] rt_tag;
        logic             rt_rdy;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    // Snooped copy of the array; the extra top slot is an empty entry shifted in on issue
    entry_t           snp   [DEPTH+1];
    entry_t           new_ent;
    entry_t           sel_ent;
    entry_t           out_ent;
    logic [DEPTH-1:0] shift_mask;
    logic             sel_found;
    logic [3:0]       count_q;
    logic [3:0]       count_d;
    logic [3:0]       tail;
    logic             full;
    logic             flush;
    logic             issue_valid;
    logic             do_issue;
    logic             do_disp;
    logic             rs_hit;
    logic             rt_hit;

`ifdef INT_IQ_FLUSH_EN
    assign flush = Flush;
`else
    assign flush = 1'b0;
`endif

    // Full comes from registered count only, so an issue never frees a slot for same-cycle dispatch
    assign full        = (count_q == 4'(DEPTH));
    assign issue_valid = sel_found & ~flush;
    assign do_issue    = issue_valid & bus.Issue_Ready;
    assign do_disp     = bus.Dispatch_en_Int & ~full;
    assign tail        = count_q - {3'b000, do_issue};

    // Oldest-ready select; shift_mask marks the selected entry and everything younger
    always_comb begin
        sel_found  = 1'b0;
        sel_ent    = '0;
        shift_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found && ent_q[i].valid && ent_q[i].rs_rdy && ent_q[i].rt_rdy) begin
                sel_found = 1'b1;
                sel_ent   = ent_q[i];
            end
            shift_mask[i] = sel_found;
        end
    end

    // Issue outputs come from registered state only (no CDB bypass); zero when idle
    always_comb begin
        out_ent = issue_valid ? sel_ent : '0;
    end

    assign bus.IssueQue_Full  = full;
    assign bus.IssueQue_Count = count_q;
    assign bus.Issue_Valid    = issue_valid;
    assign bus.Issue_Opcode   = out_ent.opcode;
    assign bus.Issue_Shfamt   = out_ent.shfamt;
    assign bus.Issue_Rs_Data  = out_ent.rs_data;
    assign bus.Issue_Rt_Data  = out_ent.rt_data;
    assign bus.Issue_Imm      = out_ent.imm;
    assign bus.Issue_Rd_Tag   = out_ent.rd_tag;
    assign bus.Issue_Branch   = out_ent.branch;

    // Build the incoming entry, including capture of a CDB broadcast in the dispatch cycle
    always_comb begin
        rs_hit          = bus.Cdb_Valid && (bus.Cdb_Tag == bus.Dispatch_Rs_Tag);
        rt_hit          = bus.Cdb_Valid && (bus.Cdb_Tag == bus.Dispatch_Rt_Tag);
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.opcode  = bus.Dispatch_Opcode;
        new_ent.shfamt  = bus.Dispatch_Shfamt;
        new_ent.imm     = bus.Dispatch_Imm_LS;
        new_ent.branch  = bus.Dispatch_Branch;
        new_ent.rd_tag  = bus.Dispatch_Rd_Tag;
        new_ent.rs_tag  = bus.Dispatch_Rs_Tag;
        new_ent.rt_tag  = bus.Dispatch_Rt_Tag;
        if (bus.Dispatch_Rs_Valid) begin
            new_ent.rs_data = bus.Dispatch_Rs_Data;
            new_ent.rs_rdy  = 1'b1;
        end else if (rs_hit) begin
            new_ent.rs_data = bus.Cdb_Data;
            new_ent.rs_rdy  = 1'b1;
        end
        // I-type: the immediate stands in for rt and is always ready
        if (bus.Dispatch_Type_I) begin
            new_ent.rt_data = bus.Dispatch_Imm_LS;
            new_ent.rt_rdy  = 1'b1;
        end else if (bus.Dispatch_Rt_Valid) begin
            new_ent.rt_data = bus.Dispatch_Rt_Data;
            new_ent.rt_rdy  = 1'b1;
        end else if (rt_hit) begin
            new_ent.rt_data = bus.Cdb_Data;
            new_ent.rt_rdy  = 1'b1;
        end
    end

    // CDB snoop on stored entries; both operands may match the same broadcast
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snp[i] = ent_q[i];
            if (ent_q[i].valid && bus.Cdb_Valid) begin
                if (!ent_q[i].rs_rdy && (ent_q[i].rs_tag == bus.Cdb_Tag)) begin
                    snp[i].rs_data = bus.Cdb_Data;
                    snp[i].rs_rdy  = 1'b1;
                end
                if (!ent_q[i].rt_rdy && (ent_q[i].rt_tag == bus.Cdb_Tag)) begin
                    snp[i].rt_data = bus.Cdb_Data;
                    snp[i].rt_rdy  = 1'b1;
                end
            end
        end
        snp[DEPTH] = '0;
    end

    // Next array: collapse over the issued slot, then write the dispatch at the tail
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = (do_issue && shift_mask[i]) ? snp[i+1] : snp[i];
            if (do_disp && (4'(i) == tail)) begin
                ent_d[i] = new_ent;
            end
            if (flush) begin
                ent_d[i] = '0;
            end
        end
    end

    // Occupancy count
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (do_disp && !do_issue) begin
            count_d = count_q + 4'd1;
        end else if (!do_disp && do_issue) begin
            count_d = count_q - 4'd1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue with an in-order scoreboard of expected issues.
module tb_int_issue_queue;

    localparam int TAG_W = 6;

    typedef struct {
        logic [3:0]       opcode;
        logic [4:0]       shfamt;
        logic [31:0]      rs;
        logic [31:0]      rt;
        logic [31:0]      imm;
        logic [TAG_W-1:0] rd;
        logic             br;
    } exp_t;

    logic Clk;
    logic Resetb;
`ifdef INT_IQ_FLUSH_EN
    logic flush;
`endif
    int   checks;
    int   errors;
    exp_t sb[$];

    int_issue_queue_if #(.TAG_W(TAG_W)) bus ();

    int_issue_queue #(
        .DEPTH(4),
        .TAG_W(TAG_W)
    ) dut (
        .Clk   (Clk),
        .Resetb(Resetb),
`ifdef INT_IQ_FLUSH_EN
        .Flush (flush),
`endif
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bus.Dispatch_en_Int   = 1'b0;
        bus.Dispatch_Opcode   = '0;
        bus.Dispatch_Shfamt   = '0;
        bus.Dispatch_Imm_LS   = '0;
        bus.Dispatch_Type_I   = 1'b0;
        bus.Dispatch_Branch   = 1'b0;
        bus.Dispatch_Rs_Data  = '0;
        bus.Dispatch_Rt_Data  = '0;
        bus.Dispatch_Rs_Tag   = '0;
        bus.Dispatch_Rt_Tag   = '0;
        bus.Dispatch_Rs_Valid = 1'b0;
        bus.Dispatch_Rt_Valid = 1'b0;
        bus.Dispatch_Rd_Tag   = '0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [4:0] shf, input logic [31:0] imm,
                        input logic ti, input logic br,
                        input logic [31:0] rs_d, input logic [TAG_W-1:0] rs_t, input logic rs_v,
                        input logic [31:0] rt_d, input logic [TAG_W-1:0] rt_t, input logic rt_v,
                        input logic [TAG_W-1:0] rd);
        bus.Dispatch_en_Int   = 1'b1;
        bus.Dispatch_Opcode   = op;
        bus.Dispatch_Shfamt   = shf;
        bus.Dispatch_Imm_LS   = imm;
        bus.Dispatch_Type_I   = ti;
        bus.Dispatch_Branch   = br;
        bus.Dispatch_Rs_Data  = rs_d;
        bus.Dispatch_Rs_Tag   = rs_t;
        bus.Dispatch_Rs_Valid = rs_v;
        bus.Dispatch_Rt_Data  = rt_d;
        bus.Dispatch_Rt_Tag   = rt_t;
        bus.Dispatch_Rt_Valid = rt_v;
        bus.Dispatch_Rd_Tag   = rd;
    endtask

    task automatic push(input logic [3:0] op, input logic [4:0] shf, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] imm,
                        input logic [TAG_W-1:0] rd, input logic br);
        exp_t e;
        e.opcode = op;
        e.shfamt = shf;
        e.rs     = rs;
        e.rt     = rt;
        e.imm    = imm;
        e.rd     = rd;
        e.br     = br;
        sb.push_back(e);
    endtask

    // Anything presented with Issue_Ready high at the falling edge issues on the next rising edge
    always @(negedge Clk) begin
        if (Resetb && bus.Issue_Valid && bus.Issue_Ready) begin
            exp_t e;
            check("issue_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("issue_rd_tag", 64'(bus.Issue_Rd_Tag), 64'(e.rd));
                check("issue_rs", 64'(bus.Issue_Rs_Data), 64'(e.rs));
                check("issue_rt", 64'(bus.Issue_Rt_Data), 64'(e.rt));
                check("issue_imm", 64'(bus.Issue_Imm), 64'(e.imm));
                check("issue_op_shf_br", 64'({bus.Issue_Opcode, bus.Issue_Shfamt, bus.Issue_Branch}),
                      64'({e.opcode, e.shfamt, e.br}));
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        Resetb = 1'b0;
`ifdef INT_IQ_FLUSH_EN
        flush  = 1'b0;
`endif
        idle();
        bus.Cdb_Valid   = 1'b0;
        bus.Cdb_Tag     = '0;
        bus.Cdb_Data    = '0;
        bus.Issue_Ready = 1'b0;

        // Reset state
        #12;
        check("rst_count", 64'(bus.IssueQue_Count), 64'd0);
        check("rst_full", 64'(bus.IssueQue_Full), 64'd0);
        check("rst_valid", 64'(bus.Issue_Valid), 64'd0);
        check("rst_rs", 64'(bus.Issue_Rs_Data), 64'd0);
        Resetb = 1'b1;
        tick();

        // Basic ADD issue
        bus.Issue_Ready = 1'b1;
        disp(4'd2, 5'd0, 32'h0, 1'b0, 1'b0, 32'd5, 6'h0, 1'b1, 32'd7, 6'h0, 1'b1, 6'h01);
        push(4'd2, 5'd0, 32'd5, 32'd7, 32'h0, 6'h01, 1'b0);
        check("basic_pre_valid", 64'(bus.Issue_Valid), 64'd0);
        tick();
        idle();
        check("basic_valid", 64'(bus.Issue_Valid), 64'd1);
        check("basic_rs", 64'(bus.Issue_Rs_Data), 64'd5);
        check("basic_rt", 64'(bus.Issue_Rt_Data), 64'd7);
        tick();
        check("basic_count", 64'(bus.IssueQue_Count), 64'd0);

        // Out-of-order issue and CDB wakeup
        bus.Issue_Ready = 1'b0;
        disp(4'd3, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h03, 1'b0, 32'h11, 6'h0, 1'b1, 6'h02);
        tick();
        disp(4'd2, 5'd3, 32'h0, 1'b0, 1'b0, 32'd1, 6'h0, 1'b1, 32'd2, 6'h0, 1'b1, 6'h03);
        tick();
        idle();
        push(4'd2, 5'd3, 32'd1, 32'd2, 32'h0, 6'h03, 1'b0);
        bus.Issue_Ready = 1'b1;
        check("ooo_sel_b", 64'(bus.Issue_Rd_Tag), 64'h03);
        tick();
        check("ooo_count", 64'(bus.IssueQue_Count), 64'd1);
        check("ooo_a_waiting", 64'(bus.Issue_Valid), 64'd0);
        bus.Cdb_Valid = 1'b1;
        bus.Cdb_Tag   = 6'h03;
        bus.Cdb_Data  = 32'hDEAD;
        push(4'd3, 5'd0, 32'hDEAD, 32'h11, 32'h0, 6'h02, 1'b0);
        #1;
        check("cdb_no_bypass", 64'(bus.Issue_Valid), 64'd0);
        tick();
        bus.Cdb_Valid = 1'b0;
        check("cdb_wake_valid", 64'(bus.Issue_Valid), 64'd1);
        check("cdb_wake_rs", 64'(bus.Issue_Rs_Data), 64'hDEAD);
        tick();
        check("cdb_count", 64'(bus.IssueQue_Count), 64'd0);

        // Both operands captured from one broadcast
        disp(4'd6, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h07, 1'b0, 32'h0, 6'h07, 1'b0, 6'h04);
        tick();
        idle();
        check("dual_waiting", 64'(bus.Issue_Valid), 64'd0);
        bus.Cdb_Valid = 1'b1;
        bus.Cdb_Tag   = 6'h07;
        bus.Cdb_Data  = 32'h55;
        push(4'd6, 5'd0, 32'h55, 32'h55, 32'h0, 6'h04, 1'b0);
        tick();
        bus.Cdb_Valid = 1'b0;
        check("dual_valid", 64'(bus.Issue_Valid), 64'd1);
        tick();

        // Fill, reject fifth, drain in age order
        bus.Issue_Ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(4'(i), 5'(i), 32'(i * 16), 1'b0, 1'b0, 32'(100 + i), 6'h0, 1'b1,
                 32'(200 + i), 6'h0, 1'b1, 6'(10 + i));
            tick();
        end
        check("fill_full", 64'(bus.IssueQue_Full), 64'd1);
        check("fill_count", 64'(bus.IssueQue_Count), 64'd4);
        disp(4'd9, 5'd0, 32'h0, 1'b0, 1'b0, 32'd1, 6'h0, 1'b1, 32'd1, 6'h0, 1'b1, 6'h20);
        tick();
        idle();
        check("reject_count", 64'(bus.IssueQue_Count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            push(4'(i), 5'(i), 32'(100 + i), 32'(200 + i), 32'(i * 16), 6'(10 + i), 1'b0);
        end
        bus.Issue_Ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("drain_count", 64'(bus.IssueQue_Count), 64'd0);
        check("drain_full", 64'(bus.IssueQue_Full), 64'd0);

        // I-type with same-cycle CDB capture on rs
        disp(4'd1, 5'd0, 32'h00FF, 1'b1, 1'b0, 32'h0, 6'h09, 1'b0, 32'hBAD, 6'h2A, 1'b0, 6'h05);
        bus.Cdb_Valid = 1'b1;
        bus.Cdb_Tag   = 6'h09;
        bus.Cdb_Data  = 32'h1200;
        push(4'd1, 5'd0, 32'h1200, 32'h00FF, 32'h00FF, 6'h05, 1'b0);
        tick();
        idle();
        bus.Cdb_Valid = 1'b0;
        check("itype_valid", 64'(bus.Issue_Valid), 64'd1);
        check("itype_rt", 64'(bus.Issue_Rt_Data), 64'h00FF);
        tick();

        // Simultaneous dispatch and issue with two entries held
        bus.Issue_Ready = 1'b0;
        disp(4'd2, 5'd0, 32'h0, 1'b0, 1'b0, 32'd30, 6'h0, 1'b1, 32'd1, 6'h0, 1'b1, 6'h1E);
        tick();
        disp(4'd2, 5'd0, 32'h0, 1'b0, 1'b0, 32'd31, 6'h0, 1'b1, 32'd1, 6'h0, 1'b1, 6'h1F);
        tick();
        disp(4'd4, 5'd0, 32'h8, 1'b0, 1'b1, 32'd32, 6'h0, 1'b1, 32'd32, 6'h0, 1'b1, 6'h21);
        bus.Issue_Ready = 1'b1;
        push(4'd2, 5'd0, 32'd30, 32'd1, 32'h0, 6'h1E, 1'b0);
        tick();
        idle();
        bus.Issue_Ready = 1'b0;
        check("simul_count", 64'(bus.IssueQue_Count), 64'd2);
        check("simul_head", 64'(bus.Issue_Rd_Tag), 64'h1F);
        push(4'd2, 5'd0, 32'd31, 32'd1, 32'h0, 6'h1F, 1'b0);
        push(4'd4, 5'd0, 32'd32, 32'd32, 32'h8, 6'h21, 1'b1);
        bus.Issue_Ready = 1'b1;
        tick();
        tick();
        check("simul_drain", 64'(bus.IssueQue_Count), 64'd0);
        bus.Issue_Ready = 1'b0;

`ifdef INT_IQ_FLUSH_EN
        // Flush with three entries, dispatch during flush dropped
        for (int i = 0; i < 3; i++) begin
            disp(4'd2, 5'd0, 32'h0, 1'b0, 1'b0, 32'(i), 6'h0, 1'b1, 32'(i), 6'h0, 1'b1, 6'(40 + i));
            tick();
        end
        bus.Issue_Ready = 1'b1;
        flush = 1'b1;
        disp(4'd2, 5'd0, 32'h0, 1'b0, 1'b0, 32'd9, 6'h0, 1'b1, 32'd9, 6'h0, 1'b1, 6'h30);
        #1;
        check("flush_valid_forced", 64'(bus.Issue_Valid), 64'd0);
        tick();
        flush = 1'b0;
        idle();
        bus.Issue_Ready = 1'b0;
        check("flush_count", 64'(bus.IssueQue_Count), 64'd0);
        check("flush_valid", 64'(bus.Issue_Valid), 64'd0);
`endif

        // Asynchronous reset mid-operation
        disp(4'd2, 5'd0, 32'h0, 1'b0, 1'b0, 32'd1, 6'h0, 1'b1, 32'd1, 6'h0, 1'b1, 6'h11);
        tick();
        disp(4'd2, 5'd0, 32'h0, 1'b0, 1'b0, 32'd2, 6'h0, 1'b1, 32'd2, 6'h0, 1'b1, 6'h12);
        tick();
        idle();
        check("pre_rst_count", 64'(bus.IssueQue_Count), 64'd2);
        #2;
        Resetb = 1'b0;
        #1;
        check("async_rst_count", 64'(bus.IssueQue_Count), 64'd0);
        check("async_rst_valid", 64'(bus.Issue_Valid), 64'd0);
        check("async_rst_rd", 64'(bus.Issue_Rd_Tag), 64'd0);
        #1;
        Resetb = 1'b1;
        tick();
        check("post_rst_count", 64'(bus.IssueQue_Count), 64'd0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
